// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU/register-bank control sequencer:
// opcodes, FSM encoding, instruction field positions and control bundles.
package alu_ctrl_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ALU   = 4'h1;
  localparam logic [3:0] OP_LOAD  = 4'h2;
  localparam logic [3:0] OP_STORE = 4'h3;
  localparam logic [3:0] OP_LDK   = 4'h4;
  localparam logic [3:0] OP_JMP   = 4'h5;
  localparam logic [3:0] OP_JZ    = 4'h6;
  localparam logic [3:0] OP_JC    = 4'h7;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [5:0] REG_NONE = 6'd0;

  localparam int F_OP_HI   = 31;
  localparam int F_OP_LO   = 28;
  localparam int F_ALUC_HI = 27;
  localparam int F_ALUC_LO = 24;
  localparam int F_A_HI    = 23;
  localparam int F_A_LO    = 18;
  localparam int F_B_HI    = 17;
  localparam int F_B_LO    = 12;
  localparam int F_C_HI    = 11;
  localparam int F_C_LO    = 6;
  localparam int F_SH_HI   = 5;
  localparam int F_SH_LO   = 4;
  localparam int F_CY      = 3;
  localparam int F_R_HI    = 27;
  localparam int F_R_LO    = 22;
  localparam int F_DA_HI   = 9;
  localparam int F_DA_LO   = 0;
  localparam int F_K_HI    = 15;
  localparam int F_K_LO    = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  typedef struct packed {
    logic [3:0]  aluc;
    logic [5:0]  sel_a;
    logic [5:0]  sel_b;
    logic [5:0]  sel_c;
    logic [1:0]  shifter;
    logic        cy_in;
    logic        kmx_sel;
    logic [15:0] kmx;
    logic [9:0]  daddr;
    logic        mw;
    logic        mr;
  } ctrl_t;

  typedef struct packed {
    logic alu;
    logic jmp;
    logic jz;
    logic jc;
    logic halt;
    logic illegal;
  } flow_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder: instruction word to datapath control
// bundle plus program-flow flags. An all-zero word decodes as a NOP.
module ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int IW = 32
) (
  input  logic [IW-1:0] ir,
  input  logic          cf,
  output ctrl_t         ctrl,
  output flow_t         flow
);

  logic [3:0] op_s;

  assign op_s = ir[F_OP_HI:F_OP_LO];

  // Opcode decode into control bundle and flow flags
  always_comb begin
    ctrl = '0;
    flow = '0;
    case (op_s)
      OP_NOP: begin
        ctrl = '0;
      end
      OP_ALU: begin
        flow.alu      = 1'b1;
        ctrl.aluc     = ir[F_ALUC_HI:F_ALUC_LO];
        ctrl.sel_a    = ir[F_A_HI:F_A_LO];
        ctrl.sel_b    = ir[F_B_HI:F_B_LO];
        ctrl.sel_c    = ir[F_C_HI:F_C_LO];
        ctrl.shifter  = ir[F_SH_HI:F_SH_LO];
        ctrl.cy_in    = ir[F_CY] ? cf : 1'b0;
      end
      OP_LOAD: begin
        ctrl.sel_c    = ir[F_R_HI:F_R_LO];
        ctrl.daddr    = ir[F_DA_HI:F_DA_LO];
        ctrl.mr       = 1'b1;
      end
      OP_STORE: begin
        ctrl.sel_b    = ir[F_R_HI:F_R_LO];
        ctrl.daddr    = ir[F_DA_HI:F_DA_LO];
        ctrl.mw       = 1'b1;
      end
      OP_LDK: begin
        ctrl.sel_c    = ir[F_R_HI:F_R_LO];
        ctrl.kmx      = ir[F_K_HI:F_K_LO];
        ctrl.kmx_sel  = 1'b1;
      end
      OP_JMP:  flow.jmp  = 1'b1;
      OP_JZ:   flow.jz   = 1'b1;
      OP_JC:   flow.jc   = 1'b1;
      OP_HALT: flow.halt = 1'b1;
      default: begin
        // 8..E: behaves as NOP, only the illegal flag is raised
        flow.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_reg_ctrl_seq.sv
// Two-cycle fetch/execute sequencer driving the ALU/register/memory datapath.
// Holds the FSM, program counter, zero/carry flags and sticky error flag.
module alu_reg_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int PC_W = 10,
  parameter int IW   = 32
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            START,
  output logic [PC_W-1:0] IADDR,
  output logic            IREQ,
  input  logic [IW-1:0]   IDATA,
  output logic [15:0]     Y_KMx_OUT,
  output logic [9:0]      DAddr,
  output logic            MW,
  output logic            MR,
  output logic            Y_X_Kmx_Sel,
  output logic [1:0]      Shifter_Sel,
  output logic [3:0]      ALUC,
  output logic            CY_TO_ALU,
  input  logic            CY_FROM_ALU,
  input  logic [15:0]     W_Block1,
  output logic [5:0]      SEL_A_RB,
  output logic [5:0]      SEL_B_RB,
  output logic [5:0]      C_SEL_RB,
  output logic            HALTED,
  output logic            ERR
);

  state_t          state_r, state_nxt_s;
  logic [PC_W-1:0] pc_r, pc_nxt_s;
  logic            cf_r, cf_nxt_s;
  logic            zf_r, zf_nxt_s;
  logic            err_r, err_nxt_s;
  logic [IW-1:0]   ir_s;
  ctrl_t           ctrl_s;
  flow_t           flow_s;
  logic            taken_s;

  // Outside EXEC the decoder sees a NOP, so every control falls to zero
  assign ir_s = (state_r == ST_EXEC) ? IDATA : '0;

  ctrl_decode #(.IW(IW)) u_decode (
    .ir   (ir_s),
    .cf   (cf_r),
    .ctrl (ctrl_s),
    .flow (flow_s)
  );

  assign taken_s = flow_s.jmp | (flow_s.jz & zf_r) | (flow_s.jc & cf_r);

  // State, PC, flags and error register with synchronous reset
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_r <= ST_IDLE;
      pc_r    <= '0;
      cf_r    <= 1'b0;
      zf_r    <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
      cf_r    <= cf_nxt_s;
      zf_r    <= zf_nxt_s;
      err_r   <= err_nxt_s;
    end
  end

  // Next-state, PC sequencing and flag update
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    cf_nxt_s    = cf_r;
    zf_nxt_s    = zf_r;
    err_nxt_s   = err_r | flow_s.illegal;
    case (state_r)
      ST_IDLE, ST_HALT: begin
        if (START) begin
          state_nxt_s = ST_FETCH;
          pc_nxt_s    = '0;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_FETCH: begin
        state_nxt_s = ST_EXEC;
      end
      ST_EXEC: begin
        if (flow_s.alu) begin
          cf_nxt_s = CY_FROM_ALU;
          zf_nxt_s = (W_Block1 == 16'h0000);
        end else begin
          cf_nxt_s = cf_r;
          zf_nxt_s = zf_r;
        end
        // Jump conditions use flags as they stood before this instruction
        if (taken_s) begin
          pc_nxt_s = ir_s[PC_W-1:0];
        end else begin
          pc_nxt_s = pc_r + {{(PC_W-1){1'b0}}, 1'b1};
        end
        if (flow_s.halt) begin
          state_nxt_s = ST_HALT;
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  assign IADDR       = pc_r;
  assign IREQ        = (state_r == ST_FETCH);
  assign HALTED      = (state_r == ST_HALT);
  assign ERR         = err_r;
  assign Y_KMx_OUT   = ctrl_s.kmx;
  assign DAddr       = ctrl_s.daddr;
  assign MW          = ctrl_s.mw;
  assign MR          = ctrl_s.mr;
  assign Y_X_Kmx_Sel = ctrl_s.kmx_sel;
  assign Shifter_Sel = ctrl_s.shifter;
  assign ALUC        = ctrl_s.aluc;
  assign CY_TO_ALU   = ctrl_s.cy_in;
  assign SEL_A_RB    = ctrl_s.sel_a;
  assign SEL_B_RB    = ctrl_s.sel_b;
  assign C_SEL_RB    = ctrl_s.sel_c;

endmodule

// File: tb/tb_alu_reg_ctrl_seq.sv
// Directed bench for alu_reg_ctrl_seq: small ROM model plus hand-computed
// expectations for each fetch and execute cycle.
module tb_alu_reg_ctrl_seq;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        START;
  logic [9:0]  IADDR;
  logic        IREQ;
  logic [31:0] IDATA = 32'h0;
  logic [15:0] Y_KMx_OUT;
  logic [9:0]  DAddr;
  logic        MW;
  logic        MR;
  logic        Y_X_Kmx_Sel;
  logic [1:0]  Shifter_Sel;
  logic [3:0]  ALUC;
  logic        CY_TO_ALU;
  logic        CY_FROM_ALU;
  logic [15:0] W_Block1;
  logic [5:0]  SEL_A_RB;
  logic [5:0]  SEL_B_RB;
  logic [5:0]  C_SEL_RB;
  logic        HALTED;
  logic        ERR;

  logic [31:0] rom [0:1023];
  int n_checks = 0;
  int n_pass   = 0;

  alu_reg_ctrl_seq #(.PC_W(10), .IW(32)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .START(START),
    .IADDR(IADDR), .IREQ(IREQ), .IDATA(IDATA),
    .Y_KMx_OUT(Y_KMx_OUT), .DAddr(DAddr), .MW(MW), .MR(MR),
    .Y_X_Kmx_Sel(Y_X_Kmx_Sel), .Shifter_Sel(Shifter_Sel), .ALUC(ALUC),
    .CY_TO_ALU(CY_TO_ALU), .CY_FROM_ALU(CY_FROM_ALU), .W_Block1(W_Block1),
    .SEL_A_RB(SEL_A_RB), .SEL_B_RB(SEL_B_RB), .C_SEL_RB(C_SEL_RB),
    .HALTED(HALTED), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (IREQ) IDATA <= rom[IADDR];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic fetch(input string tag, input logic [9:0] addr);
    chk({tag, "_ireq"}, {31'd0, IREQ}, 32'd1);
    chk({tag, "_iaddr"}, {22'd0, IADDR}, {22'd0, addr});
    tick;
  endtask

  task automatic no_side(input string tag);
    chk(tag, {19'd0, MW, MR, C_SEL_RB, Y_X_Kmx_Sel, ALUC}, 32'd0);
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_a"}, {1'b0, Y_KMx_OUT, DAddr, MW, MR, Y_X_Kmx_Sel, Shifter_Sel}, 32'd0);
    chk({tag, "_b"}, {6'd0, ALUC, CY_TO_ALU, SEL_A_RB, SEL_B_RB, C_SEL_RB, IREQ, HALTED, ERR}, 32'd0);
    chk({tag, "_iaddr"}, {22'd0, IADDR}, 32'd0);
  endtask

  function automatic logic [31:0] enc_alu(input logic [3:0] aluc, input logic [5:0] a,
                                          input logic [5:0] b, input logic [5:0] c,
                                          input logic [1:0] sh, input logic cy);
    return {4'h1, aluc, a, b, c, sh, cy, 3'b000};
  endfunction

  function automatic logic [31:0] enc_ldk(input logic [5:0] c, input logic [15:0] k);
    return {4'h4, c, 6'd0, k};
  endfunction

  function automatic logic [31:0] enc_mem(input logic [3:0] op, input logic [5:0] r, input logic [9:0] addr);
    return {op, r, 12'd0, addr};
  endfunction

  function automatic logic [31:0] enc_jmp(input logic [3:0] op, input logic [9:0] t);
    return {op, 18'd0, t};
  endfunction

  initial begin
    RESET_N = 1'b0; START = 1'b0; CY_FROM_ALU = 1'b0; W_Block1 = 16'h0000;
    for (int i = 0; i < 1024; i++) rom[i] = 32'h0000_0000;
    rom[0] = enc_ldk(6'd1, 16'h00FF);
    rom[1] = enc_alu(4'h3, 6'd1, 6'd1, 6'd2, 2'b01, 1'b1);
    rom[2] = 32'hF000_0000;
    tick; tick;
    all_zero("rst");
    RESET_N = 1'b1;
    tick;
    chk("idle_wait", {31'd0, IREQ}, 32'd0);

    // Program A: LDK, ALU with carry-use, HALT
    START = 1'b1; tick; START = 1'b0;
    fetch("a0", 10'h000);
    CY_FROM_ALU = 1'b1; W_Block1 = 16'h0000;
    chk("a_ldk", {9'd0, C_SEL_RB, Y_X_Kmx_Sel, Y_KMx_OUT}, {9'd0, 6'd1, 1'b1, 16'h00FF});
    chk("a_ldk_mem", {30'd0, MW, MR}, 32'd0);
    tick;
    fetch("a1", 10'h001);
    chk("a_alu_c", {28'd0, ALUC}, 32'h3);
    chk("a_alu_regs", {14'd0, SEL_A_RB, SEL_B_RB, C_SEL_RB}, {14'd0, 6'd1, 6'd1, 6'd2});
    chk("a_alu_sh", {30'd0, Shifter_Sel}, 32'd1);
    chk("a_alu_cyin_ldk_no_flag", {31'd0, CY_TO_ALU}, 32'd0);
    chk("a_alu_kmx", {31'd0, Y_X_Kmx_Sel}, 32'd0);
    CY_FROM_ALU = 1'b1; W_Block1 = 16'h1234;
    tick;
    fetch("a2", 10'h002);
    chk("a_halt_exec", {31'd0, HALTED}, 32'd0);
    tick;
    chk("a_halted", {30'd0, HALTED, IREQ}, 32'd2);
    no_side("a_halt_quiet");
    tick;
    chk("a_halt_stays", {31'd0, HALTED}, 32'd1);

    // Program B: jumps on ZF/CF, LOAD keeps CF, PC wrap, reset mid-STORE
    rom[0] = enc_jmp(4'h5, 10'h100);
    rom[1] = 32'h0; rom[2] = 32'h0;
    rom[10'h100] = enc_alu(4'h1, 6'd3, 6'd4, 6'd5, 2'b00, 1'b0);
    rom[10'h101] = enc_jmp(4'h6, 10'h020);
    rom[10'h020] = enc_alu(4'h2, 6'd6, 6'd7, 6'd8, 2'b10, 1'b1);
    rom[10'h021] = enc_jmp(4'h6, 10'h040);
    rom[10'h022] = enc_mem(4'h2, 6'd7, 10'h155);
    rom[10'h023] = enc_alu(4'h5, 6'd1, 6'd2, 6'd3, 2'b00, 1'b1);
    rom[10'h024] = enc_jmp(4'h7, 10'h3FF);
    rom[10'h3FF] = 32'h0;
    START = 1'b1; tick; START = 1'b0;
    chk("b_restart", {31'd0, HALTED}, 32'd0);
    fetch("b0", 10'h000);
    tick;
    fetch("b1_jmp", 10'h100);
    W_Block1 = 16'h0000; CY_FROM_ALU = 1'b0;
    tick;
    fetch("b2", 10'h101);
    tick;
    fetch("b3_jz_taken", 10'h020);
    chk("b_cyin_cf0", {31'd0, CY_TO_ALU}, 32'd0);
    W_Block1 = 16'h0001; CY_FROM_ALU = 1'b1;
    tick;
    fetch("b4_jz_not", 10'h021);
    tick;
    fetch("b5", 10'h022);
    chk("b_load", {15'd0, MR, MW, C_SEL_RB, DAddr}, {15'd0, 1'b1, 1'b0, 6'd7, 10'h155});
    W_Block1 = 16'h0000; CY_FROM_ALU = 1'b0;
    tick;
    fetch("b6", 10'h023);
    chk("b_load_keeps_cf", {31'd0, CY_TO_ALU}, 32'd1);
    W_Block1 = 16'h0005; CY_FROM_ALU = 1'b1;
    tick;
    fetch("b7", 10'h024);
    tick;
    fetch("b8_jc_taken", 10'h3FF);
    no_side("b_nop_quiet");
    rom[0] = enc_mem(4'h3, 6'd9, 10'h2AA);
    tick;
    fetch("b9_wrap", 10'h000);
    chk("b_store", {15'd0, MW, MR, SEL_B_RB, DAddr}, {15'd0, 1'b1, 1'b0, 6'd9, 10'h2AA});
    RESET_N = 1'b0;
    tick;
    all_zero("b_rst_mid_store");
    RESET_N = 1'b1;
    tick;
    chk("b_idle_after_rst", {31'd0, IREQ}, 32'd0);

    // Program C: illegal opcode, START ignored while running, HALT restart
    rom[0] = 32'hA3FF_FFFF;
    rom[1] = 32'h0;
    rom[2] = 32'hF000_0000;
    START = 1'b1; tick; START = 1'b0;
    fetch("c0", 10'h000);
    no_side("c_ill_quiet");
    chk("c_ill_mr", {31'd0, MR}, 32'd0);
    chk("c_err_clear", {31'd0, ERR}, 32'd0);
    tick;
    chk("c_err_set", {31'd0, ERR}, 32'd1);
    START = 1'b1;
    fetch("c1", 10'h001);
    tick;
    START = 1'b0;
    fetch("c2_start_ignored", 10'h002);
    tick;
    chk("c_halted", {30'd0, HALTED, ERR}, 32'd3);
    START = 1'b1; tick; START = 1'b0;
    chk("c_restart", {31'd0, HALTED}, 32'd0);
    fetch("c_restart", 10'h000);
    chk("c_err_sticky", {31'd0, ERR}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
